// File: rtl/lwc_rdi_pool.sv
// lwc_rdi_pool
//   Randomness prefetch pool for the masked Romulus LWC core. Buffers RNDW-bit
//   random words from the external rdi port in a DEPTH-entry circular buffer and
//   hands each word to exactly one of NCH requesting consumers under round-robin
//   arbitration. After reset or flush the pool first fills completely (PRIME)
//   before any grant is issued (RUN), so consumers never see a cold-start stall.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   rdi_data   random word from TRNG/PRNG
//   rdi_valid  rdi_data valid
//   rdi_ready  pool accepts a word this cycle
//   flush      discard buffered randomness and re-enter PRIME
//   req        per-channel level-sensitive request
//   gnt        one-hot grant (or zero)
//   rnd_data   word for the granted channel, zero when nothing is granted
//   level      number of stored words
//   primed     pool is in RUN
//   starve     sticky: a request arrived in RUN while the pool was empty
module lwc_rdi_pool #(
  parameter int unsigned RNDW  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCH   = 2,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RNDW-1:0] rdi_data,
  input  logic            rdi_valid,
  output logic            rdi_ready,
  input  logic            flush,
  input  logic [NCH-1:0]  req,
  output logic [NCH-1:0]  gnt,
  output logic [RNDW-1:0] rnd_data,
  output logic [LW-1:0]   level,
  output logic            primed,
  output logic            starve
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [0:0] PRIME = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [RNDW-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [LW-1:0]   count_nxt;
  logic [GW-1:0]   last;
  logic [GW-1:0]   gidx;
  logic [0:0]      state;
  logic            found;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  int unsigned     idx;

  assign full      = (count == LW'(DEPTH));
  assign empty     = (count == '0);
  // Full blocks a push even when a pop happens in the same cycle.
  assign rdi_ready = rst & ~flush & ~full;
  assign push      = rdi_valid & rdi_ready;
  assign level     = count;
  assign primed    = (state == RUN);

  // Round-robin: first set request at or after last+1, wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(last) + 32'd1 + i) % NCH;
      for (int unsigned j = 0; j < NCH; j++) begin
        if (!found && (j == idx) && req[j]) begin
          found = 1'b1;
          gidx  = GW'(j);
        end
      end
    end
  end

  // Grants never depend on rdi_valid: a word pushed this cycle is only
  // grantable from the next cycle on.
  assign pop = rst & ~flush & (state == RUN) & ~empty & found;

  always_comb begin
    gnt      = '0;
    rnd_data = '0;
    if (pop) begin
      gnt[gidx] = 1'b1;
      rnd_data  = mem[rd_ptr];
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + LW'(1);
    else if (pop && !push)
      count_nxt = count - LW'(1);
  end

  // Storage is not cleared on reset/flush; stale words are unreachable
  // because both pointers and the count are reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rdi_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state  <= PRIME;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= GW'(NCH - 1);
      starve <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last   <= gidx;
      end
      count <= count_nxt;
      if (state == PRIME && count_nxt == LW'(DEPTH))
        state <= RUN;
      if (state == RUN && (|req) && empty)
        starve <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lwc_rdi_pool.sv
module tb_lwc_rdi_pool;
  localparam int unsigned RNDW  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCH   = 3;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [RNDW-1:0] rdi_data;
  logic            rdi_valid;
  logic            rdi_ready;
  logic            flush;
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  gnt;
  logic [RNDW-1:0] rnd_data;
  logic [LW-1:0]   level;
  logic            primed;
  logic            starve;

  lwc_rdi_pool #(.RNDW(RNDW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .rdi_data(rdi_data), .rdi_valid(rdi_valid),
    .rdi_ready(rdi_ready), .flush(flush), .req(req), .gnt(gnt),
    .rnd_data(rnd_data), .level(level), .primed(primed), .starve(starve)
  );

  always #5 clk = ~clk;

  // Reference model: pool contents as a plain queue of words.
  logic [RNDW-1:0] m_q[$];
  bit              m_run;
  int unsigned     m_last;
  bit              m_starve;
  logic [RNDW-1:0] next_word;

  typedef struct {
    logic [NCH-1:0]  g;
    logic [RNDW-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_run    = 0;
    m_last   = NCH - 1;
    m_starve = 0;
  endtask

  task automatic step(input bit v, input logic [NCH-1:0] r, input bit f, input bit rs);
    int unsigned size_pre;
    int unsigned g;
    bit          gr;
    bit          exp_ready;
    exp_t        e;
    @(negedge clk);
    check("level", 64'(level), 64'(m_q.size()));
    check("primed", 64'(primed), 64'(m_run));
    check("starve", 64'(starve), 64'(m_starve));
    rdi_valid = v;
    rdi_data  = next_word;
    req       = r;
    flush     = f;
    rst       = rs;
    size_pre  = m_q.size();
    exp_ready = rs && !f && (size_pre < DEPTH);
    gr = 0;
    g  = 0;
    if (rs && !f && m_run && size_pre > 0) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        int unsigned c;
        c = (m_last + 1 + i) % NCH;
        if (!gr && r[c]) begin
          gr = 1;
          g  = c;
        end
      end
    end
    if (gr) begin
      e.g = '0;
      e.g[g] = 1'b1;
      e.d = m_q[0];
      exp_q.push_back(e);
    end
    #1;
    check("rdi_ready", 64'(rdi_ready), 64'(exp_ready));
    if (!rs || f) begin
      model_reset();
    end else begin
      if (m_run && r != 0 && size_pre == 0) m_starve = 1;
      if (gr) begin
        void'(m_q.pop_front());
        m_last = g;
      end
      if (v && exp_ready) begin
        m_q.push_back(next_word);
        next_word = next_word + 1;
      end
      if (!m_run && m_q.size() == DEPTH) m_run = 1;
    end
  endtask

  // Monitor: every presented grant must match the oldest expected delivery.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (gnt !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", 64'(gnt), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("gnt", 64'(gnt), 64'(e.g));
          check("rnd_data", 64'(rnd_data), 64'(e.d));
        end
      end else begin
        check("rnd_data_idle", 64'(rnd_data), 64'(0));
      end
    end
  end

  initial begin
    logic [NCH-1:0] rr;
    bit vv, ff, rs;
    vectors     = 0;
    miscompares = 0;
    next_word   = 1;
    rst         = 1'b0;
    flush       = 1'b0;
    req         = '0;
    rdi_valid   = 1'b0;
    rdi_data    = '0;
    model_reset();

    repeat (3) step(0, 3'b000, 0, 0);
    // cold start with two requesters held
    repeat (10) step(1, 3'b011, 0, 1);
    // full pool, no requests, then a single pop
    repeat (3) step(1, 3'b000, 0, 1);
    step(1, 3'b001, 0, 1);
    repeat (2) step(1, 3'b000, 0, 1);
    // starvation then a late word
    repeat (6) step(0, 3'b001, 0, 1);
    step(1, 3'b001, 0, 1);
    step(0, 3'b001, 0, 1);
    step(0, 3'b000, 0, 1);
    // flush with three words buffered
    repeat (3) step(1, 3'b000, 0, 1);
    step(0, 3'b011, 1, 1);
    repeat (2) step(0, 3'b011, 0, 1);
    // reset together with flush mid-stream, then re-prime
    repeat (6) step(1, 3'b011, 0, 1);
    step(1, 3'b011, 1, 0);
    repeat (8) step(1, 3'b101, 0, 1);
    repeat (6) step(1, 3'b111, 0, 1);
    // randomized traffic
    repeat (600) begin
      vv = ($urandom_range(0, 3) != 0);
      rr = NCH'($urandom);
      ff = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 96) != 0);
      step(vv, rr, ff, rs);
    end
    step(0, 3'b000, 0, 1);
    @(negedge clk);
    #3;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
